vq_ctrl: RTL
============

VQ_CTRL -- requirements
Module: vq_ctrl

Interface
REQ-001 Parameter N_VEP, default 64, number of VEPs on an 8x8 grid; tag of VEP i = i = {y[2:0], x[2:0]}.
REQ-002 Parameter N_PIX, default 4096, number of image pixels processed per run.
REQ-003 clk  input  1  positive-edge clock; the only clock.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  run request; sampled in IDLE only.
REQ-006 done  output  1  one-cycle pulse at end of run.
REQ-007 RAM_W_A  output  6  codebook address.
REQ-008 RAM_W_OE  output  1  codebook read enable.
REQ-009 RAM_W_Q  input  24  codebook data; valid the cycle after A/OE.
REQ-010 weight_initial  output  24  broadcast to all VEPs; wired directly to RAM_W_Q.
REQ-011 weight_update  output  N_VEP  per-VEP write enable; bit i drives VEP i; at most one-hot.
REQ-012 RAM_IF_A  output  12  image address.
REQ-013 RAM_IF_OE  output  1  image read enable.
REQ-014 RAM_IF_Q  input  24  pixel {B,G,R}; valid the cycle after A/OE.
REQ-015 pixel  output  24  registered pixel broadcast to all VEPs.
REQ-016 dist_all  input  10*N_VEP  concatenated VEP manhattan_distance; bits [10i+9:10i] belong to VEP i.
REQ-017 RAM_O_A  output  12  result address.
REQ-018 RAM_O_D  output  6  winner tag.
REQ-019 RAM_O_WE  output  1  result write enable.

Function
REQ-020 FSM states IDLE, LOAD, FETCH, LATCH, CMP, WRITE, DONE; single state register.
REQ-021 IDLE: all enables low; start=1 -> LOAD with load counter k=0; start=0 -> stay.
REQ-022 LOAD runs exactly N_VEP+1 cycles, k=0..N_VEP: for k<N_VEP, RAM_W_A=k and RAM_W_OE=1; for k>=1, weight_update bit k-1 =1, all other bits 0.
REQ-023 LOAD at k=N_VEP -> FETCH with pixel counter p=0; weight_update is all-zero in every other state.
REQ-024 FETCH (1 cycle): RAM_IF_A=p, RAM_IF_OE=1 -> LATCH.
REQ-025 LATCH (1 cycle): pixel <= RAM_IF_Q at end of cycle -> CMP.
REQ-026 CMP (1 cycle): winner <= index of minimum 10-bit unsigned distance over all N_VEP entries -> WRITE.
REQ-027 Tie rule: among equal minima, lowest index wins.
REQ-028 WRITE (1 cycle): RAM_O_A=p, RAM_O_D=winner, RAM_O_WE=1; if p==N_PIX-1 -> DONE, else p<=p+1 -> FETCH.
REQ-029 Throughput: exactly 4 cycles per pixel; total run = (N_VEP+1) + 4*N_PIX + 1 cycles from start acceptance to done.
REQ-030 DONE (1 cycle): done=1 -> IDLE; p and k wrap to 0.
REQ-031 start asserted outside IDLE has no effect; start held high through DONE begins a new run on the IDLE cycle that follows.
REQ-032 RAM_W_OE, RAM_IF_OE, RAM_O_WE, done and weight_update are asserted only in the states stated above, and are 0 in every other state.
REQ-033 pixel and winner hold their value outside LATCH and CMP, respectively.

Reset
REQ-034 rst=1 at a clock edge: state=IDLE, k=0, p=0, pixel=0, winner=0; all enables, done, and weight_update=0 from the next cycle.
REQ-035 Reset mid-run aborts immediately: no further RAM_O writes, and no partial weight_update after the reset edge.
REQ-036 rst has priority over start in the same cycle.

Verification
REQ-037 Load: RAM_W[i]=24'h010101*i, pulse start -> weight_update bit i high exactly at cycle i+2 after start with weight_initial=RAM_W[i]; 65 LOAD cycles.
REQ-038 Winner: N_PIX=4, dist_all all 10'd500 except VEP 37=10'd3 -> RAM_O_D=6'd37 written at addresses 0..3, one write each 4 cycles.
REQ-039 Tie: VEPs 5, 12 and 63 = 10'd0, rest 10'd1023 -> RAM_O_D=6'd5.
REQ-040 Completion: N_VEP=64, N_PIX=4 -> done pulses for exactly 1 cycle, 82 cycles after start is sampled; FSM then returns to IDLE; start pulsed during the run is ignored.
REQ-041 Reset mid-operation: rst asserted in CMP of pixel 2 -> no RAM_O_WE for pixel 2, all outputs 0 next cycle; new start reruns LOAD from k=0.
REQ-042 Back-to-back: start held high -> second LOAD begins the cycle after IDLE following done.

Source files
------------

// File: rtl/vq_ctrl.sv
// Vector-quantisation controller: loads the codebook into the VEP array, then streams
// pixels through it and writes the index of the closest VEP for each pixel.
module vq_ctrl #(
  parameter int unsigned N_VEP = 64,
  parameter int unsigned N_PIX = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  output logic [5:0]            RAM_W_A,
  output logic                  RAM_W_OE,
  input  logic [23:0]           RAM_W_Q,
  output logic [23:0]           weight_initial,
  output logic [N_VEP-1:0]      weight_update,
  output logic [11:0]           RAM_IF_A,
  output logic                  RAM_IF_OE,
  input  logic [23:0]           RAM_IF_Q,
  output logic [23:0]           pixel,
  input  logic [10*N_VEP-1:0]   dist_all,
  output logic [11:0]           RAM_O_A,
  output logic [5:0]            RAM_O_D,
  output logic                  RAM_O_WE
);

  localparam int unsigned KW = $clog2(N_VEP + 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StFetch, StLatch, StCmp, StWrite, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [11:0]     p_q, p_d;
  logic [23:0]     pixel_q, pixel_d;
  logic [5:0]      winner_q, winner_d;
  logic [5:0]      min_idx;
  logic [9:0]      min_val;

  assign weight_initial = RAM_W_Q;
  assign pixel          = pixel_q;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    min_val = dist_all[9:0];
    min_idx = '0;
    for (int i = 1; i < N_VEP; i++) begin
      if (dist_all[10*i +: 10] < min_val) begin
        min_val = dist_all[10*i +: 10];
        min_idx = 6'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    p_d           = p_q;
    pixel_d       = pixel_q;
    winner_d      = winner_q;
    done          = 1'b0;
    RAM_W_A       = '0;
    RAM_W_OE      = 1'b0;
    weight_update = '0;
    RAM_IF_A      = '0;
    RAM_IF_OE     = 1'b0;
    RAM_O_A       = '0;
    RAM_O_D       = '0;
    RAM_O_WE      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          k_d     = '0;
        end
      end
      StLoad: begin
        if (k_q < KW'(N_VEP)) begin
          RAM_W_A  = 6'(k_q);
          RAM_W_OE = 1'b1;
        end
        // Codebook word for VEP k-1 arrives this cycle.
        if (k_q != '0) begin
          weight_update = {{(N_VEP-1){1'b0}}, 1'b1} << (k_q - KW'(1));
        end
        if (k_q == KW'(N_VEP)) begin
          state_d = StFetch;
          k_d     = '0;
          p_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StFetch: begin
        RAM_IF_A  = p_q;
        RAM_IF_OE = 1'b1;
        state_d   = StLatch;
      end
      StLatch: begin
        pixel_d = RAM_IF_Q;
        state_d = StCmp;
      end
      StCmp: begin
        winner_d = min_idx;
        state_d  = StWrite;
      end
      StWrite: begin
        RAM_O_A  = p_q;
        RAM_O_D  = winner_q;
        RAM_O_WE = 1'b1;
        if (p_q == 12'(N_PIX - 1)) begin
          state_d = StDone;
        end else begin
          p_d     = p_q + 12'd1;
          state_d = StFetch;
        end
      end
      StDone: begin
        done    = 1'b1;
        p_d     = '0;
        k_d     = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      p_q      <= '0;
      pixel_q  <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      p_q      <= p_d;
      pixel_q  <= pixel_d;
      winner_q <= winner_d;
    end
  end

endmodule
